branch_sequencer: RTL and testbench
===================================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 64, instruction address and LR/CTR width (32 or 64 only).
REQ-002 Parameter RESET_VEC, default 0, first fetch address after reset.
REQ-003 Parameter RAS_DEPTH, default 8, return-address-stack entries (power of 2, 2..32).
REQ-004 i_clk  in  1  clock, rising edge; i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_stall  in  1  hold CIA/LR/CTR/RAS; i_valid  in  1  i_instr is a branch to execute.
REQ-006 i_instr  in  32  instruction, LSB-0 numbering: opcode [31:26], LI [25:2], AA [1], LK [0], BO [25:21], BI [20:16], BD [15:2], BH [12:11], XO [10:1].
REQ-007 i_mode32  in  1  32-bit mode; i_cr  in  32  condition register, ISA CR bit n = i_cr[31-n].
REQ-008 i_ctr_we/i_lr_we  in  1 each, i_spr_wdata  in  ADDR_W  mtctr/mtlr write port.
REQ-009 o_nia  out  ADDR_W  next instruction address; o_lr, o_ctr  out  ADDR_W  registered LR/CTR.
REQ-010 o_taken  out  1  current valid branch taken; o_ras_pred  out  ADDR_W  RAS top; o_ras_valid  out  1.
REQ-011 o_err  out  1  set for: i_valid&i_stall, unsupported opcode/XO, bcctr with BO[2]=0.

Function
REQ-012 FSM states BOOT, RUN; BOOT entered on reset, o_nia=RESET_VEC, CIA not incremented; BOOT->RUN on first non-stalled edge.
REQ-013 RUN, i_valid=0: o_nia=CIA+4 combinationally.
REQ-014 Supported: opcode 18 (b), 16 (bc), 19/XO 16 (bclr), 19/XO 528 (bcctr); others -> o_err=1, o_nia=CIA+4, no state change.
REQ-015 b: target = AA ? EXTS(LI||00) : CIA+EXTS(LI||00); always taken.
REQ-016 bc: target = AA ? EXTS(BD||00) : CIA+EXTS(BD||00); bclr: LR[ADDR_W-1:2]||00; bcctr: CTR[ADDR_W-1:2]||00.
REQ-017 ctr_ok = BO[2] | ((CTR-1 != 0) ^ BO[1]); cond_ok = BO[4] | (CR[BI] == BO[3]); taken = ctr_ok & cond_ok (bcctr ignores ctr_ok).
REQ-018 CTR <= CTR-1 at edge when valid bc/bclr, BO[2]=0, not stalled; wraps 0 -> all-ones.
REQ-019 LK=1: LR <= CIA+4 at edge regardless of taken; bclr uses pre-update LR as target.
REQ-020 o_nia = taken ? target : CIA+4, same cycle as i_valid (zero latency); CIA <= o_nia on each non-stalled edge.
REQ-021 i_mode32=1: o_nia, LR write and target upper 32 bits forced 0; CTR zero test uses CTR[31:0] only.
REQ-022 i_stall=1: CIA, LR, CTR, RAS hold; o_nia still driven combinationally.
REQ-023 SPR write same cycle as branch update of same register: write port wins.

Reset
REQ-024 On i_rst: state=BOOT, CIA=RESET_VEC, LR=0, CTR=0, RAS empty, o_taken=0, o_ras_valid=0, o_err=0 (when i_valid=0).
REQ-025 Reset mid-stall or mid-branch discards pending update; no partial LR/CTR write.

Configuration
REQ-026 Macro BRANCH_SEQUENCER_RAS_EN defined: LK=1 valid branch pushes CIA+4; bclr with BH=00 pops; full push overwrites oldest (pointer wraps); pop on empty leaves o_ras_valid=0.
REQ-027 Simultaneous push and pop (bclrl): pop then push, depth unchanged.
REQ-028 Macro undefined: no RAS storage, o_ras_pred=0, o_ras_valid=0 constant; all other behaviour identical.

Verification
REQ-029 Reset, RESET_VEC=0x100, no valid for 3 cycles -> o_nia 0x100, 0x104, 0x108, 0x10C.
REQ-030 CIA=0x1000, b LI=-4 (0x3FFFFFC), AA=0, LK=1 -> o_nia=0x0FFC, o_taken=1, o_lr=0x1004 next cycle.
REQ-031 CTR=1, bc BO=10000 (decrement, branch if CTR!=0), BD=+8 -> not taken, o_nia=CIA+4, o_ctr=0; repeat -> taken, o_ctr=all-ones.
REQ-032 i_mode32=1, LR=0xFFFF_FFFF_8000_0003, bclr BO=10100 -> o_nia=0x8000_0000.
REQ-033 RAS_EN, RAS_DEPTH=2: three bl pushes A,B,C then three bclr BH=00 -> o_ras_pred C, B, then o_ras_valid=0.
REQ-034 i_stall=1 with i_valid=1 -> o_err=1, CIA/LR/CTR unchanged next cycle.

Source files
------------

// File: rtl/branch_sequencer.sv
// Branch sequencer: next-instruction-address generation for b/bc/bclr/bcctr with LR/CTR.
// Optional return-address stack, enabled by defining BRANCH_SEQUENCER_RAS_EN.
module branch_sequencer #(
    parameter int unsigned       ADDR_W    = 64,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int unsigned       RAS_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_valid,
    input  logic [31:0]       i_instr,
    input  logic              i_mode32,
    input  logic [31:0]       i_cr,
    input  logic              i_ctr_we,
    input  logic              i_lr_we,
    input  logic [ADDR_W-1:0] i_spr_wdata,
    output logic [ADDR_W-1:0] o_nia,
    output logic [ADDR_W-1:0] o_lr,
    output logic [ADDR_W-1:0] o_ctr,
    output logic              o_taken,
    output logic [ADDR_W-1:0] o_ras_pred,
    output logic              o_ras_valid,
    output logic              o_err
);

    typedef enum logic {StBoot, StRun} state_e;

    localparam logic [ADDR_W-1:0] Low32Mask = ADDR_W'(32'hFFFF_FFFF);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cia_q, cia_d;
    logic [ADDR_W-1:0] lr_q, lr_d;
    logic [ADDR_W-1:0] ctr_q, ctr_d;

    logic [5:0]        opcode;
    logic [9:0]        xo;
    logic [4:0]        bo;
    logic [4:0]        bi;
    logic              aa;
    logic              lk;
    logic              is_b, is_bc, is_bclr, is_bcctr;
    logic              legal;
    logic              exec;
    logic              upd;
    logic [ADDR_W-1:0] addr_mask;
    logic [ADDR_W-1:0] li_ext;
    logic [ADDR_W-1:0] bd_ext;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] ctr_m1;
    logic [ADDR_W-1:0] nia_raw;
    logic              ctr_nz;
    logic              ctr_ok;
    logic              cond_ok;
    logic              taken;

    // Instruction field decode
    always_comb begin
        opcode   = i_instr[31:26];
        xo       = i_instr[10:1];
        bo       = i_instr[25:21];
        bi       = i_instr[20:16];
        aa       = i_instr[1];
        lk       = i_instr[0];
        is_b     = (opcode == 6'd18);
        is_bc    = (opcode == 6'd16);
        is_bclr  = (opcode == 6'd19) && (xo == 10'd16);
        is_bcctr = (opcode == 6'd19) && (xo == 10'd528);
        // bcctr cannot decrement the register it branches through
        legal    = is_b || is_bc || is_bclr || (is_bcctr && bo[2]);
        exec     = (state_q == StRun) && i_valid && legal;
        upd      = exec && !i_stall;
    end

    // Branch target and condition evaluation
    always_comb begin
        addr_mask = i_mode32 ? Low32Mask : '1;
        li_ext    = {{(ADDR_W - 26){i_instr[25]}}, i_instr[25:2], 2'b00};
        bd_ext    = {{(ADDR_W - 16){i_instr[15]}}, i_instr[15:2], 2'b00};
        seq_addr  = (cia_q + ADDR_W'(4)) & addr_mask;
        ctr_m1    = ctr_q - ADDR_W'(1);
        ctr_nz    = i_mode32 ? (ctr_m1[31:0] != 32'd0) : (ctr_m1 != '0);
        ctr_ok    = bo[2] | (ctr_nz ^ bo[1]);
        cond_ok   = bo[4] | (i_cr[5'd31 - bi] == bo[3]);

        target = '0;
        taken  = 1'b0;
        if (is_b) begin
            target = aa ? li_ext : cia_q + li_ext;
            taken  = 1'b1;
        end else if (is_bc) begin
            target = aa ? bd_ext : cia_q + bd_ext;
            taken  = ctr_ok & cond_ok;
        end else if (is_bclr) begin
            target = {lr_q[ADDR_W-1:2], 2'b00};
            taken  = ctr_ok & cond_ok;
        end else if (is_bcctr) begin
            target = {ctr_q[ADDR_W-1:2], 2'b00};
            taken  = cond_ok;
        end

        if (state_q == StBoot) begin
            nia_raw = RESET_VEC;
        end else if (exec && taken) begin
            nia_raw = target;
        end else begin
            nia_raw = cia_q + ADDR_W'(4);
        end
    end

    // Next-state logic; the SPR write port overrides any branch side effect
    always_comb begin
        state_d = state_q;
        cia_d   = cia_q;
        lr_d    = lr_q;
        ctr_d   = ctr_q;
        if (!i_stall) begin
            state_d = StRun;
            cia_d   = nia_raw & addr_mask;
            if (upd && lk) begin
                lr_d = seq_addr;
            end
            if (upd && (is_bc || is_bclr) && !bo[2]) begin
                ctr_d = ctr_m1;
            end
            if (i_lr_we) begin
                lr_d = i_spr_wdata;
            end
            if (i_ctr_we) begin
                ctr_d = i_spr_wdata;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StBoot;
            cia_q   <= RESET_VEC;
            lr_q    <= '0;
            ctr_q   <= '0;
        end else begin
            state_q <= state_d;
            cia_q   <= cia_d;
            lr_q    <= lr_d;
            ctr_q   <= ctr_d;
        end
    end

    assign o_nia   = nia_raw & addr_mask;
    assign o_lr    = lr_q;
    assign o_ctr   = ctr_q;
    assign o_taken = exec & taken;
    assign o_err   = i_valid & (i_stall | ~legal);

`ifdef BRANCH_SEQUENCER_RAS_EN
    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PtrW-1:0]   ras_ptr_q, ras_ptr_d;
    logic [CntW-1:0]   ras_cnt_q, ras_cnt_d;
    logic [PtrW-1:0]   ras_top;
    logic [PtrW-1:0]   ras_wr_idx;
    logic              ras_wr;
    logic              ras_push;
    logic              ras_pop;
    logic [1:0]        bh;

    // ras_ptr_q is the next free slot; a full push overwrites the oldest entry
    always_comb begin
        bh         = i_instr[12:11];
        ras_push   = upd && lk;
        ras_pop    = upd && is_bclr && (bh == 2'b00) && (ras_cnt_q != '0);
        ras_top    = ras_ptr_q - PtrW'(1);
        ras_ptr_d  = ras_ptr_q;
        ras_cnt_d  = ras_cnt_q;
        ras_wr     = 1'b0;
        ras_wr_idx = ras_ptr_q;
        if (ras_push && ras_pop) begin
            ras_wr     = 1'b1;
            ras_wr_idx = ras_top;
        end else if (ras_push) begin
            ras_wr    = 1'b1;
            ras_ptr_d = ras_ptr_q + PtrW'(1);
            if (ras_cnt_q != CntW'(RAS_DEPTH)) begin
                ras_cnt_d = ras_cnt_q + CntW'(1);
            end
        end else if (ras_pop) begin
            ras_ptr_d = ras_top;
            ras_cnt_d = ras_cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ras_ptr_q <= '0;
            ras_cnt_q <= '0;
        end else begin
            ras_ptr_q <= ras_ptr_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (ras_wr) begin
            ras_mem[ras_wr_idx] <= seq_addr;
        end
    end

    assign o_ras_valid = (ras_cnt_q != '0);
    assign o_ras_pred  = o_ras_valid ? ras_mem[ras_top] : '0;
`else
    assign o_ras_valid = 1'b0;
    assign o_ras_pred  = '0;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed cases plus randomized branches against a
// behavioural model of the architected CIA/LR/CTR/RAS state.
module tb_branch_sequencer;

    localparam int unsigned ADDR_W    = 64;
    localparam logic [63:0] RV        = 64'h100;
    localparam int unsigned RAS_DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        valid;
    logic [31:0] instr;
    logic        mode32;
    logic [31:0] cr;
    logic        ctr_we;
    logic        lr_we;
    logic [63:0] spr_wdata;
    logic [63:0] nia;
    logic [63:0] lr;
    logic [63:0] ctr;
    logic        taken;
    logic [63:0] ras_pred;
    logic        ras_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          m_boot;
    logic [63:0] m_cia;
    logic [63:0] m_lr;
    logic [63:0] m_ctr;
    logic [63:0] m_ras[$];

    branch_sequencer #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RV),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_stall     (stall),
        .i_valid     (valid),
        .i_instr     (instr),
        .i_mode32    (mode32),
        .i_cr        (cr),
        .i_ctr_we    (ctr_we),
        .i_lr_we     (lr_we),
        .i_spr_wdata (spr_wdata),
        .o_nia       (nia),
        .o_lr        (lr),
        .o_ctr       (ctr),
        .o_taken     (taken),
        .o_ras_pred  (ras_pred),
        .o_ras_valid (ras_valid),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_cia  = RV;
        m_lr   = '0;
        m_ctr  = '0;
        m_ras.delete();
    endtask

    task automatic idle();
        stall  = 1'b0;
        valid  = 1'b0;
        instr  = '0;
        ctr_we = 1'b0;
        lr_we  = 1'b0;
    endtask

    // One clock: check combinational outputs, advance the model, check LR/CTR.
    task automatic cycle();
        logic [4:0]  bo;
        logic [4:0]  bi;
        logic [63:0] mask, tgt, nxt, link, ctr_dec;
        logic        legal, tk, ctr_ok, cond_ok;
        longint      off;
        int          kind;
        #1;
        bo   = instr[25:21];
        bi   = instr[20:16];
        mask = mode32 ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        kind = 0;
        if (instr[31:26] == 6'd18) kind = 1;
        else if (instr[31:26] == 6'd16) kind = 2;
        else if (instr[31:26] == 6'd19 && instr[10:1] == 10'd16) kind = 3;
        else if (instr[31:26] == 6'd19 && instr[10:1] == 10'd528 && bo[2]) kind = 4;
        legal   = valid && kind != 0 && !m_boot;
        ctr_dec = m_ctr - 64'd1;
        ctr_ok  = bo[2] || (((ctr_dec & mask) != 64'd0) != bo[1]);
        cond_ok = bo[4] || (cr[31 - int'(bi)] == bo[3]);
        tk      = 1'b0;
        tgt     = '0;
        if (legal) begin
            case (kind)
                1: begin
                    off = longint'($signed(instr[25:2])) * 4;
                    tgt = instr[1] ? off : m_cia + off;
                    tk  = 1'b1;
                end
                2: begin
                    off = longint'($signed(instr[15:2])) * 4;
                    tgt = instr[1] ? off : m_cia + off;
                    tk  = ctr_ok && cond_ok;
                end
                3: begin
                    tgt = m_lr & ~64'h3;
                    tk  = ctr_ok && cond_ok;
                end
                default: begin
                    tgt = m_ctr & ~64'h3;
                    tk  = cond_ok;
                end
            endcase
        end
        nxt  = (m_boot ? RV : (tk ? tgt : m_cia + 64'd4)) & mask;
        link = (m_cia + 64'd4) & mask;
        chk("nia", nia, nxt);
        chk("taken", 64'(taken), 64'(tk));
        chk("err", 64'(err), 64'(valid && (stall || kind == 0)));
        chk("ras_valid", 64'(ras_valid), 64'(m_ras.size() != 0));
`ifdef BRANCH_SEQUENCER_RAS_EN
        if (m_ras.size() != 0) chk("ras_pred", ras_pred, m_ras[$]);
`else
        chk("ras_pred", ras_pred, 64'd0);
`endif
        @(posedge clk);
        if (!stall) begin
            if (legal) begin
                if (instr[0]) m_lr = link;
                if ((kind == 2 || kind == 3) && !bo[2]) m_ctr = ctr_dec;
`ifdef BRANCH_SEQUENCER_RAS_EN
                if (kind == 3 && instr[12:11] == 2'b00 && m_ras.size() != 0) void'(m_ras.pop_back());
                if (instr[0]) begin
                    if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
                    m_ras.push_back(link);
                end
`endif
            end
            if (lr_we) m_lr = spr_wdata;
            if (ctr_we) m_ctr = spr_wdata;
            m_boot = 1'b0;
            m_cia  = nxt;
        end
        #1;
        chk("lr", lr, m_lr);
        chk("ctr", ctr, m_ctr);
    endtask

    initial begin
        logic [63:0] links[3];
        logic [31:0] base;
        int          r;

        rst       = 1'b1;
        mode32    = 1'b0;
        cr        = '0;
        spr_wdata = '0;
        idle();
        model_reset();
        #12;
        chk("rst_nia", nia, RV);
        chk("rst_taken", 64'(taken), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_lr", lr, 64'd0);
        chk("rst_ctr", ctr, 64'd0);
        chk("rst_ras_valid", 64'(ras_valid), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Boot then sequential fetch
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("boot_seq", nia, 64'h100 + 64'(4 * i));
            cycle();
        end

        // Absolute jump to 0x1000, then b -4 with link
        valid = 1'b1;
        instr = {6'd18, 24'h000400, 1'b1, 1'b0};
        cycle();
        instr = {6'd18, 24'hFFFFFF, 1'b0, 1'b1};
        #1;
        chk("b_back_nia", nia, 64'h0FFC);
        chk("b_back_taken", 64'(taken), 64'd1);
        cycle();
        chk("b_back_lr", lr, 64'h1004);

        // CTR boundary: 1 -> 0 not taken, 0 -> all-ones taken
        idle();
        ctr_we    = 1'b1;
        spr_wdata = 64'd1;
        cycle();
        idle();
        valid = 1'b1;
        instr = {6'd16, 5'b10000, 5'd0, 14'd2, 1'b0, 1'b0};
        #1;
        chk("bdnz1_nia", nia, 64'h1004);
        chk("bdnz1_taken", 64'(taken), 64'd0);
        cycle();
        chk("bdnz1_ctr", ctr, 64'd0);
        #1;
        chk("bdnz2_nia", nia, 64'h100C);
        chk("bdnz2_taken", 64'(taken), 64'd1);
        cycle();
        chk("bdnz2_ctr", ctr, 64'hFFFF_FFFF_FFFF_FFFF);

        // 32-bit mode bclr clears the upper half and low two bits
        idle();
        lr_we     = 1'b1;
        spr_wdata = 64'hFFFF_FFFF_8000_0003;
        cycle();
        idle();
        mode32 = 1'b1;
        valid  = 1'b1;
        instr  = {6'd19, 5'b10100, 5'd0, 5'd0, 10'd16, 1'b0};
        #1;
        chk("bclr32_nia", nia, 64'h8000_0000);
        cycle();
        mode32 = 1'b0;

        // Valid while stalled: error, no architected update
        stall = 1'b1;
        instr = {6'd16, 5'b10000, 5'd0, 14'd2, 1'b0, 1'b1};
        #1;
        chk("stall_err", 64'(err), 64'd1);
        cycle();
        chk("stall_lr", lr, 64'hFFFF_FFFF_8000_0003);
        chk("stall_ctr", ctr, 64'hFFFF_FFFF_FFFF_FFFF);
        idle();
        #1;
        chk("stall_cia", nia, 64'h8000_0004);
        cycle();

        // Unsupported opcode and unsupported bcctr form
        valid = 1'b1;
        instr = {6'd31, 26'h0};
        #1;
        chk("illegal_err", 64'(err), 64'd1);
        chk("illegal_nia", nia, 64'h8000_0008);
        cycle();
        instr = {6'd19, 5'b10000, 5'd0, 5'd0, 10'd528, 1'b0};
        #1;
        chk("bcctr_dec_err", 64'(err), 64'd1);
        cycle();

        // SPR write port beats a same-cycle branch update
        instr     = {6'd16, 5'b10000, 5'd0, 14'd2, 1'b0, 1'b1};
        ctr_we    = 1'b1;
        lr_we     = 1'b1;
        spr_wdata = 64'd5;
        cycle();
        chk("spr_win_ctr", ctr, 64'd5);
        chk("spr_win_lr", lr, 64'd5);
        idle();

`ifdef BRANCH_SEQUENCER_RAS_EN
        // Depth-2 RAS: push A, B, C then pop C, B, then empty
        for (int i = 0; i < 3; i++) begin
            valid    = 1'b1;
            instr    = {6'd18, 24'd1, 1'b0, 1'b1};
            links[i] = m_cia + 64'd4;
            cycle();
        end
        instr = {6'd19, 5'b10100, 5'd0, 5'd0, 10'd16, 1'b0};
        #1;
        chk("ras_pop_c", ras_pred, links[2]);
        cycle();
        #1;
        chk("ras_pop_b", ras_pred, links[1]);
        cycle();
        #1;
        chk("ras_empty", 64'(ras_valid), 64'd0);
        cycle();
        idle();
`else
        links[0] = '0;
        chk("ras_off_valid", 64'(ras_valid), 64'(links[0]));
`endif

        // Reset while a linking, decrementing branch is pending
        valid = 1'b1;
        instr = {6'd16, 5'b10000, 5'd0, 14'd2, 1'b0, 1'b1};
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_nia", nia, RV);
        chk("midrst_lr", lr, 64'd0);
        chk("midrst_ctr", ctr, 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_hold_ctr", ctr, 64'd0);
        idle();
        rst = 1'b0;
        model_reset();

        // Randomized branches against the model
        for (int n = 0; n < 400; n++) begin
            r    = $urandom_range(0, 9);
            base = $urandom();
            case (r)
                0, 1, 2: instr = {6'd18, base[25:0]};
                3, 4, 5: instr = {6'd16, base[25:0]};
                6:       instr = {6'd19, base[25:11], 10'd16, base[0]};
                7:       instr = {6'd19, base[25:11], 10'd528, base[0]};
                8:       instr = {6'd31, base[25:0]};
                default: instr = {6'd19, base[25:11], 10'd50, base[0]};
            endcase
            valid     = ($urandom_range(0, 9) < 7);
            stall     = ($urandom_range(0, 9) == 0);
            mode32    = ($urandom_range(0, 7) == 0);
            cr        = $urandom();
            ctr_we    = ($urandom_range(0, 7) == 0);
            lr_we     = ($urandom_range(0, 7) == 0);
            spr_wdata = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 3))
                                                     : {$urandom(), $urandom()};
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
